// File: rtl/dti_arb_pkg.sv
// Shared types and helpers for the DTI round-robin arbiter.
package dti_arb_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_st_e;

  // Index width that stays legal for the degenerate single-input case.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder: first asserted req at or after ptr+1, wrapping.
module rr_prio_enc #(
  parameter int N_IN  = 4,
  parameter int W_IDX = 2
) (
  input  logic [N_IN-1:0]  req,
  input  logic [W_IDX-1:0] ptr,
  output logic [W_IDX-1:0] gnt_idx,
  output logic             gnt_vld
);

  int               c;
  logic [W_IDX-1:0] ci;

  // Walk from the farthest candidate down so the closest one after ptr wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    c       = 0;
    ci      = '0;
    for (int k = N_IN; k >= 1; k--) begin
      c  = (int'(ptr) + k) % N_IN;
      ci = W_IDX'(c);
      if (req[ci]) begin
        gnt_idx = ci;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dti_rr_arb.sv
// N-input round-robin arbiter feeding a single registered output slot.
module dti_rr_arb
  import dti_arb_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int W_DATA = 16,
  parameter int W_IDX  = idx_w(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*W_DATA-1:0] din_data,
  input  logic [N_IN-1:0]        din_valid,
  output logic [N_IN-1:0]        din_ready,
  output logic [W_DATA-1:0]      dout_data,
  output logic [W_IDX-1:0]       dout_idx,
  output logic                   dout_valid,
  input  logic                   dout_ready
);

  slot_st_e         state, state_nxt;
  logic [W_IDX-1:0] ptr, gnt_idx;
  logic             gnt_vld, accept, in_hs, out_hs;

  rr_prio_enc #(.N_IN(N_IN), .W_IDX(W_IDX)) u_enc (
    .req     (din_valid),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (in_hs)       state_nxt = FULL;
    else if (out_hs) state_nxt = EMPTY;
  end

  // rst gates accept so no handshake is reported while reset is held.
  always_comb begin
    dout_valid = (state == FULL);
    accept     = rst && ((state == EMPTY) || dout_ready);
    in_hs      = accept && gnt_vld;
    out_hs     = dout_valid && dout_ready;
    din_ready  = '0;
    if (in_hs) din_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= W_IDX'(N_IN - 1);
      dout_data <= '0;
      dout_idx  <= '0;
    end else if (in_hs) begin
      ptr       <= gnt_idx;
      dout_data <= din_data[gnt_idx*W_DATA +: W_DATA];
      dout_idx  <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_dti_rr_arb.sv
// Directed vector table on a 4-input arbiter plus a randomized 3-input soak.
module tb_dti_rr_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-input instance
  logic        rst;
  logic [63:0] din_data;
  logic [3:0]  din_valid, din_ready;
  logic [15:0] dout_data;
  logic [1:0]  dout_idx;
  logic        dout_valid, dout_ready;

  dti_rr_arb #(.N_IN(4), .W_DATA(16)) dut (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid),
    .din_ready(din_ready), .dout_data(dout_data), .dout_idx(dout_idx),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  // 3-input instance
  logic        rst3;
  logic [47:0] din_data3;
  logic [2:0]  din_valid3, din_ready3;
  logic [15:0] dout_data3;
  logic [1:0]  dout_idx3;
  logic        dout_valid3, dout_ready3;

  dti_rr_arb #(.N_IN(3), .W_DATA(16)) dut3 (
    .clk(clk), .rst(rst3), .din_data(din_data3), .din_valid(din_valid3),
    .din_ready(din_ready3), .dout_data(dout_data3), .dout_idx(dout_idx3),
    .dout_valid(dout_valid3), .dout_ready(dout_ready3)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic        rdy;
    logic [3:0]  exp_rdy;
    logic        exp_v;
    logic [1:0]  exp_idx;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl[17];

  // input 3..0 data words
  localparam logic [63:0] D = {16'h3333, 16'h00AB, 16'h1111, 16'h0F00};

  logic [11:0] seq[3];
  logic [11:0] exp_seq[4];
  logic [2:0]  hs_in;
  logic        stall, legal;
  logic [15:0] hold_d;
  logic [1:0]  hold_i;
  int          n_out;

  initial begin
    // round-robin over all four, then stall, drain, single input, wrap-around
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0F00};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h1111};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h00AB};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h3333};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0F00};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h0F00};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h0F00};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h0F00};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h0F00};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h0F00};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0F00};
    tbl[11] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 16'h00AB};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 16'h00AB};
    tbl[13] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h3333};
    tbl[14] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0F00};
    tbl[15] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h3333};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 16'h3333};

    rst = 1'b0; din_data = D; din_valid = 4'b1111; dout_ready = 1'b1;
    rst3 = 1'b0; din_data3 = '0; din_valid3 = '0; dout_ready3 = 1'b0;

    @(posedge clk); @(posedge clk); #1;
    chk("reset dout_valid", 32'(dout_valid), 32'd0);
    chk("reset din_ready",  32'(din_ready),  32'd0);
    chk("reset dout_idx",   32'(dout_idx),   32'd0);
    chk("reset dout_data",  32'(dout_data),  32'd0);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      din_valid = tbl[i].vld; dout_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d din_ready", i), 32'(din_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d dout_valid", i), 32'(dout_valid), 32'(tbl[i].exp_v));
      chk($sformatf("v%0d dout_idx", i),   32'(dout_idx),   32'(tbl[i].exp_idx));
      chk($sformatf("v%0d dout_data", i),  32'(dout_data),  32'(tbl[i].exp_data));
    end

    // Mid-cycle reset while FULL
    din_valid = 4'b0010; dout_ready = 1'b0;
    #1;
    chk("rst seq din_ready", 32'(din_ready), 32'b0010);
    @(posedge clk); #1;
    chk("rst seq full idx", 32'(dout_idx), 32'd1);
    din_valid = 4'b1111;
    #2; rst = 1'b0; #1;
    chk("async rst dout_valid", 32'(dout_valid), 32'd0);
    chk("async rst din_ready",  32'(din_ready),  32'd0);
    chk("async rst dout_data",  32'(dout_data),  32'd0);
    @(posedge clk); #1;
    rst = 1'b1; dout_ready = 1'b1;
    #1;
    chk("post rst din_ready", 32'(din_ready), 32'b0001);
    @(posedge clk); #1;
    chk("post rst dout_valid", 32'(dout_valid), 32'd1);
    chk("post rst dout_idx",   32'(dout_idx),   32'd0);

    // Randomized soak on the 3-input instance
    for (int i = 0; i < 3; i++) seq[i] = '0;
    for (int i = 0; i < 4; i++) exp_seq[i] = '0;
    hs_in = '0; stall = 1'b0; hold_d = '0; hold_i = '0; n_out = 0;
    @(posedge clk); #1;
    rst3 = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (hs_in[i]) begin seq[i] = seq[i] + 12'd1; din_valid3[i] = 1'b0; end
      if (stall) begin
        chk("n3 hold valid", 32'(dout_valid3), 32'd1);
        chk("n3 hold data",  32'(dout_data3),  32'(hold_d));
        chk("n3 hold idx",   32'(dout_idx3),   32'(hold_i));
      end
      for (int i = 0; i < 3; i++) begin
        if (!din_valid3[i]) din_valid3[i] = 1'($urandom_range(0, 1));
        din_data3[i*16 +: 16] = {4'(i), seq[i]};
      end
      dout_ready3 = 1'($urandom_range(0, 1));
      #1;
      hs_in = din_ready3;
      legal = ($countones(din_ready3) <= 1) && ((din_ready3 & ~din_valid3) == 3'b000);
      chk("n3 din_ready legal", 32'(legal), 32'd1);
      if (dout_valid3 && dout_ready3) begin
        chk("n3 dout_idx range", 32'(dout_idx3 < 2'd3), 32'd1);
        if (dout_idx3 < 2'd3) begin
          chk("n3 order", 32'(dout_data3), 32'({2'b00, dout_idx3, exp_seq[dout_idx3]}));
          exp_seq[dout_idx3] = exp_seq[dout_idx3] + 12'd1;
        end
        n_out++;
      end
      stall  = dout_valid3 && !dout_ready3;
      hold_d = dout_data3;
      hold_i = dout_idx3;
    end
    chk("n3 throughput", 32'(n_out > 1000), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
